// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: gameend codes, controller states and win-line masks.
// The display stage decodes gameend using the same constants.
package ttt_pkg;

  localparam logic [1:0] GE_NONE  = 2'b00;
  localparam logic [1:0] GE_O_WIN = 2'b01;
  localparam logic [1:0] GE_X_WIN = 2'b10;
  localparam logic [1:0] GE_DRAW  = 2'b11;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_CHECK = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  // Cells are row-major with bit 0 top-left; entry 0 is the top row.
  localparam logic [7:0][8:0] WIN_LINES = {
    9'h054, 9'h111,           // anti-diagonal, main diagonal
    9'h124, 9'h092, 9'h049,   // columns 2, 1, 0
    9'h1C0, 9'h038, 9'h007    // rows 2, 1, 0
  };

  function automatic logic is_onehot9(input logic [8:0] v);
    return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational win detector: flags a board that fully covers any of the eight lines.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [8:0] i_board,
  output logic       o_win
);

  always_comb begin
    o_win = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if ((i_board & WIN_LINES[l]) == WIN_LINES[l]) o_win = 1'b1;
    end
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe controller: takes cell/new-game button edges, keeps both boards,
// alternates turns and reports win/draw codes for the dot-matrix display stage.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter logic FIRST_O = 1'b1
) (
  input  logic       clk_10000Hz,
  input  logic       reset,
  input  logic [8:0] key,
  input  logic       new_game,
  output logic       whosTurn,
  output logic [1:0] gameend,
  output logic [8:0] board_o,
  output logic [8:0] board_x,
  output logic [3:0] move_cnt,
  output logic       illegal_move
);

  state_t     r_state;
  logic [8:0] r_key_prev;
  logic       r_ng_prev;
  logic [8:0] r_board_o;
  logic [8:0] r_board_x;
  logic [3:0] r_move_cnt;
  logic [1:0] r_gameend;
  logic       r_turn;
  logic       r_illegal;

  logic [8:0] w_key_rise;
  logic       w_ng_rise;
  logic [8:0] w_occupied;
  logic [8:0] w_mover_board;
  logic       w_win;

  assign w_key_rise    = key & ~r_key_prev;
  assign w_ng_rise     = new_game & ~r_ng_prev;
  assign w_occupied    = r_board_o | r_board_x;
  // whosTurn is still the mover's value while in CHECK, so it selects the board just played.
  assign w_mover_board = r_turn ? r_board_o : r_board_x;

  ttt_line_check u_line_check (
    .i_board (w_mover_board),
    .o_win   (w_win)
  );

  always_ff @(posedge clk_10000Hz) begin
    if (!reset) begin
      r_state    <= ST_PLAY;
      r_key_prev <= 9'd0;
      r_ng_prev  <= 1'b0;
      r_board_o  <= 9'd0;
      r_board_x  <= 9'd0;
      r_move_cnt <= 4'd0;
      r_gameend  <= GE_NONE;
      r_turn     <= FIRST_O;
      r_illegal  <= 1'b0;
    end else begin
      r_key_prev <= key;
      r_ng_prev  <= new_game;
      r_illegal  <= 1'b0;
      if (w_ng_rise) begin
        r_state    <= ST_PLAY;
        r_board_o  <= 9'd0;
        r_board_x  <= 9'd0;
        r_move_cnt <= 4'd0;
        r_gameend  <= GE_NONE;
        r_turn     <= FIRST_O;
      end else begin
        case (r_state)
          ST_PLAY: begin
            if (w_key_rise != 9'd0) begin
              if (is_onehot9(w_key_rise) && ((w_key_rise & w_occupied) == 9'd0)) begin
                if (r_turn) r_board_o <= r_board_o | w_key_rise;
                else        r_board_x <= r_board_x | w_key_rise;
                r_move_cnt <= r_move_cnt + 4'd1;
                r_state    <= ST_CHECK;
              end else begin
                r_illegal <= 1'b1;
              end
            end
          end
          ST_CHECK: begin
            if (w_win) begin
              r_gameend <= r_turn ? GE_O_WIN : GE_X_WIN;
              r_state   <= ST_OVER;
            end else if (r_move_cnt == 4'd9) begin
              r_gameend <= GE_DRAW;
              r_state   <= ST_OVER;
            end else begin
              r_turn  <= ~r_turn;
              r_state <= ST_PLAY;
            end
          end
          ST_OVER: begin
            r_state <= ST_OVER;
          end
          default: begin
            r_state <= ST_PLAY;
          end
        endcase
      end
    end
  end

  assign whosTurn     = r_turn;
  assign gameend      = r_gameend;
  assign board_o      = r_board_o;
  assign board_x      = r_board_x;
  assign move_cnt     = r_move_cnt;
  assign illegal_move = r_illegal;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Self-checking bench for ttt_game_ctrl: directed vector table, hand-written corner
// sequences and random play, all checked against a cell-array game model.
module tb_ttt_game_ctrl;

  localparam logic FIRST_O = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] key;
  logic       ng;
  logic       whosTurn;
  logic [1:0] gameend;
  logic [8:0] board_o;
  logic [8:0] board_x;
  logic [3:0] move_cnt;
  logic       illegal_move;

  ttt_game_ctrl #(.FIRST_O(FIRST_O)) dut (
    .clk_10000Hz  (clk),
    .reset        (rst_n),
    .key          (key),
    .new_game     (ng),
    .whosTurn     (whosTurn),
    .gameend      (gameend),
    .board_o      (board_o),
    .board_x      (board_x),
    .move_cnt     (move_cnt),
    .illegal_move (illegal_move)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cells hold 0 empty, 1 O, 2 X; counts are derived from the cells.
  int         m_cell[9];
  bit         m_turn;
  int         m_res;
  bit         m_pend;
  bit         m_ill;
  logic [8:0] m_pk;
  bit         m_png;
  int         lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                              '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic int m_filled();
    int n = 0;
    for (int i = 0; i < 9; i++) if (m_cell[i] != 0) n++;
    return n;
  endfunction

  function automatic logic [8:0] m_mask(input int who);
    logic [8:0] v = '0;
    for (int i = 0; i < 9; i++) v[i] = (m_cell[i] == who);
    return v;
  endfunction

  task automatic m_new_game();
    for (int i = 0; i < 9; i++) m_cell[i] = 0;
    m_turn = FIRST_O;
    m_res  = 0;
    m_pend = 0;
  endtask

  task automatic model_step(input logic r, input logic [8:0] k, input logic n);
    logic [8:0] rise;
    bit ngr, won;
    int cnt, idx, who;
    m_ill = 0;
    if (!r) begin
      m_new_game();
      m_pk  = '0;
      m_png = 0;
    end else begin
      rise  = k & ~m_pk;
      ngr   = n && !m_png;
      m_pk  = k;
      m_png = n;
      if (ngr) begin
        m_new_game();
      end else if (m_pend) begin
        m_pend = 0;
        who = m_turn ? 1 : 2;
        won = 0;
        for (int l = 0; l < 8; l++)
          if (m_cell[lines[l][0]] == who && m_cell[lines[l][1]] == who && m_cell[lines[l][2]] == who)
            won = 1;
        if (won) m_res = m_turn ? 1 : 2;
        else if (m_filled() == 9) m_res = 3;
        else m_turn = !m_turn;
      end else if (m_res == 0 && rise != 0) begin
        cnt = 0;
        idx = 0;
        for (int i = 0; i < 9; i++) if (rise[i]) begin cnt++; idx = i; end
        if (cnt == 1 && m_cell[idx] == 0) begin
          m_cell[idx] = m_turn ? 1 : 2;
          m_pend = 1;
        end else begin
          m_ill = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst_n, key, ng);
    #1;
    chk("model board_o",  board_o,      m_mask(1));
    chk("model board_x",  board_x,      m_mask(2));
    chk("model move_cnt", move_cnt,     m_filled());
    chk("model whosTurn", whosTurn,     m_turn);
    chk("model gameend",  gameend,      m_res);
    chk("model illegal",  illegal_move, m_ill);
    chk("disjoint",       board_o & board_x, 0);
    chk("popcount",       $countones(board_o | board_x), move_cnt);
  endtask

  task automatic press(input int idx);
    key = 9'(1) << idx;
    tick();
    key = '0;
    tick();
  endtask

  task automatic play(input int seq[$]);
    foreach (seq[i]) press(seq[i]);
  endtask

  typedef struct {
    logic       rst_n;
    logic [8:0] key;
    logic       ng;
    logic [8:0] bo;
    logic [8:0] bx;
    logic [3:0] cnt;
    logic       turn;
    logic [1:0] ge;
    logic       ill;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0;
    key   = '0;
    ng    = 1'b0;

    // reset, first move, O win on a row, then illegal presses
    tbl.push_back('{1'b0, 9'h000, 1'b0, 9'h000, 9'h000, 4'd0, 1'b1, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 9'h000, 1'b0, 9'h000, 9'h000, 4'd0, 1'b1, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 9'h000, 1'b0, 9'h000, 9'h000, 4'd0, 1'b1, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 9'h000, 1'b0, 9'h000, 9'h000, 4'd0, 1'b1, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 9'h010, 1'b0, 9'h010, 9'h000, 4'd1, 1'b1, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 9'h010, 1'b0, 9'h010, 9'h000, 4'd1, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 9'h000, 1'b0, 9'h010, 9'h000, 4'd1, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 9'h000, 1'b1, 9'h000, 9'h000, 4'd0, 1'b1, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 9'h000, 1'b0, 9'h000, 9'h000, 4'd0, 1'b1, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 9'h001, 1'b0, 9'h001, 9'h000, 4'd1, 1'b1, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 9'h000, 1'b0, 9'h001, 9'h000, 4'd1, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 9'h008, 1'b0, 9'h001, 9'h008, 4'd2, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 9'h000, 1'b0, 9'h001, 9'h008, 4'd2, 1'b1, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 9'h002, 1'b0, 9'h003, 9'h008, 4'd3, 1'b1, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 9'h000, 1'b0, 9'h003, 9'h008, 4'd3, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 9'h010, 1'b0, 9'h003, 9'h018, 4'd4, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 9'h000, 1'b0, 9'h003, 9'h018, 4'd4, 1'b1, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 9'h004, 1'b0, 9'h007, 9'h018, 4'd5, 1'b1, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 9'h000, 1'b0, 9'h007, 9'h018, 4'd5, 1'b1, 2'd1, 1'b0});
    tbl.push_back('{1'b1, 9'h100, 1'b0, 9'h007, 9'h018, 4'd5, 1'b1, 2'd1, 1'b0});
    tbl.push_back('{1'b1, 9'h000, 1'b0, 9'h007, 9'h018, 4'd5, 1'b1, 2'd1, 1'b0});
    tbl.push_back('{1'b1, 9'h000, 1'b1, 9'h000, 9'h000, 4'd0, 1'b1, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 9'h000, 1'b0, 9'h000, 9'h000, 4'd0, 1'b1, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 9'h010, 1'b0, 9'h010, 9'h000, 4'd1, 1'b1, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 9'h000, 1'b0, 9'h010, 9'h000, 4'd1, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 9'h010, 1'b0, 9'h010, 9'h000, 4'd1, 1'b0, 2'd0, 1'b1});
    tbl.push_back('{1'b1, 9'h000, 1'b0, 9'h010, 9'h000, 4'd1, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 9'h028, 1'b0, 9'h010, 9'h000, 4'd1, 1'b0, 2'd0, 1'b1});
    tbl.push_back('{1'b1, 9'h000, 1'b0, 9'h010, 9'h000, 4'd1, 1'b0, 2'd0, 1'b0});

    #2;
    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n;
      key   = tbl[i].key;
      ng    = tbl[i].ng;
      tick();
      chk($sformatf("tbl%0d board_o", i),  board_o,      tbl[i].bo);
      chk($sformatf("tbl%0d board_x", i),  board_x,      tbl[i].bx);
      chk($sformatf("tbl%0d move_cnt", i), move_cnt,     tbl[i].cnt);
      chk($sformatf("tbl%0d whosTurn", i), whosTurn,     tbl[i].turn);
      chk($sformatf("tbl%0d gameend", i),  gameend,      tbl[i].ge);
      chk($sformatf("tbl%0d illegal", i),  illegal_move, tbl[i].ill);
    end

    // draw on the 9th move
    ng = 1'b1; tick(); ng = 1'b0; tick();
    play('{0, 1, 2, 4, 3, 5, 7, 6, 8});
    chk("draw gameend", gameend, 2'b11);
    chk("draw move_cnt", move_cnt, 4'd9);

    // 9th move completing a line is a win, not a draw
    ng = 1'b1; tick(); ng = 1'b0; tick();
    play('{0, 1, 2, 4, 3, 5, 7, 8, 6});
    chk("win9 gameend", gameend, 2'b01);
    chk("win9 move_cnt", move_cnt, 4'd9);

    // new_game with a simultaneous key edge in PLAY at move_cnt 3
    ng = 1'b1; tick(); ng = 1'b0; tick();
    play('{0, 1, 2});
    key = 9'h001; ng = 1'b1; tick();
    chk("ng_play board_o", board_o, 9'h000);
    chk("ng_play move_cnt", move_cnt, 4'd0);
    chk("ng_play whosTurn", whosTurn, FIRST_O);
    key = '0; ng = 1'b0; tick();

    // new_game while OVER
    play('{0, 3, 1, 4, 2});
    chk("over gameend", gameend, 2'b01);
    ng = 1'b1; tick();
    chk("ng_over gameend", gameend, 2'b00);
    ng = 1'b0; tick();

    // key edge during CHECK is discarded silently, then new_game during CHECK
    key = 9'h001; tick();
    key = 9'h003; tick();
    chk("check_key board_o", board_o, 9'h001);
    chk("check_key illegal", illegal_move, 1'b0);
    key = 9'h000; tick();
    key = 9'h004; tick();
    key = 9'h000; ng = 1'b1; tick();
    chk("ng_check board_x", board_x, 9'h000);
    chk("ng_check move_cnt", move_cnt, 4'd0);
    ng = 1'b0; tick(); tick();

    // a held key makes exactly one move
    key = 9'h004;
    repeat (50) tick();
    chk("hold move_cnt", move_cnt, 4'd1);
    key = '0; tick();

    // reset mid-game at move_cnt 4
    play('{0, 1, 3});
    chk("mid move_cnt", move_cnt, 4'd4);
    rst_n = 1'b0; tick();
    chk("rst board_o", board_o, 9'h000);
    chk("rst board_x", board_x, 9'h000);
    chk("rst move_cnt", move_cnt, 4'd0);
    chk("rst whosTurn", whosTurn, FIRST_O);
    rst_n = 1'b1; tick();

    // random play
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 40)      key = '0;
      else if (r < 85) key = 9'(1) << $urandom_range(0, 8);
      else             key = 9'($urandom_range(0, 511));
      ng    = ($urandom_range(0, 99) < 3);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
